// File: rtl/latch_phase_sequencer_pkg.sv
// Shared definitions for the two-phase latch clock sequencer.
// Holds the sequencer state encoding and the default field widths.
// No ports; imported by latch_phase_sequencer and phase_timer.
package latch_phase_sequencer_pkg;

  localparam int CNT_W_DEF   = 4;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_PH2  = 3'd3,
    ST_GAP2 = 3'd4
  } state_t;

endpackage

// File: rtl/latch_phase_sequencer_phase_timer.sv
// phase_timer: loadable down-counter timing one sequencer state.
// Ports: clk/rst (sync, active-high), load + load_val reload the count,
//        tc is high while the count is zero (last cycle of the state).
module phase_timer
  import latch_phase_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // A state of length d is loaded with d-1, so tc is seen on its d-th cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/latch_phase_sequencer.sv
// latch_phase_sequencer: generates non-overlapping phi1/phi2 latch enables
// in bursts of transfers (PH1, GAP1, PH2, GAP2 per transfer).
// Ports: clk, rst (sync active-high); start, stop, ph_width, gap_width,
//        burst_len in; phi1, phi2, busy, done, xfer_cnt out (all registered).
module latch_phase_sequencer
  import latch_phase_sequencer_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   ph_width,
  input  logic [CNT_W-1:0]   gap_width,
  input  logic [BURST_W-1:0] burst_len,
  output logic               phi1,
  output logic               phi2,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] xfer_cnt
);

  state_t             state;
  logic [CNT_W-1:0]   cfg_ph;
  logic [CNT_W-1:0]   cfg_gap;
  logic [BURST_W-1:0] cfg_burst;
  logic               stop_pend;
  logic               tc;
  logic               load;
  logic [CNT_W-1:0]   load_val;
  logic [BURST_W-1:0] next_cnt;
  logic               burst_end;

  // Timer reload value: a width of 0 behaves as 1, and the count runs d-1..0.
  function automatic logic [CNT_W-1:0] dur_m1(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - 1'b1;
  endfunction

  assign next_cnt  = xfer_cnt + BURST_W'(1);
  // A stop raised in the final GAP2 cycle still ends this transfer.
  assign burst_end = ((cfg_burst != '0) && (next_cnt == cfg_burst)) || stop_pend || stop;

  // Timer reload accompanies every state entry.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (state)
      ST_IDLE: if (start) begin
        load     = 1'b1;
        load_val = dur_m1(ph_width);
      end
      ST_PH1: if (tc) begin
        load     = 1'b1;
        load_val = dur_m1(cfg_gap);
      end
      ST_GAP1: if (tc) begin
        load     = 1'b1;
        load_val = dur_m1(cfg_ph);
      end
      ST_PH2: if (tc) begin
        load     = 1'b1;
        load_val = dur_m1(cfg_gap);
      end
      ST_GAP2: if (tc && !burst_end) begin
        load     = 1'b1;
        load_val = dur_m1(cfg_ph);
      end
      default: begin
        load     = 1'b0;
        load_val = '0;
      end
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  // Outputs are set from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phi1      <= 1'b0;
      phi2      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      xfer_cnt  <= '0;
      stop_pend <= 1'b0;
      cfg_ph    <= '0;
      cfg_gap   <= '0;
      cfg_burst <= '0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && stop) begin
        stop_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: if (start) begin
          cfg_ph    <= ph_width;
          cfg_gap   <= gap_width;
          cfg_burst <= burst_len;
          xfer_cnt  <= '0;
          stop_pend <= stop;
          state     <= ST_PH1;
          phi1      <= 1'b1;
          busy      <= 1'b1;
        end
        ST_PH1: if (tc) begin
          state <= ST_GAP1;
          phi1  <= 1'b0;
        end
        ST_GAP1: if (tc) begin
          state <= ST_PH2;
          phi2  <= 1'b1;
        end
        ST_PH2: if (tc) begin
          state <= ST_GAP2;
          phi2  <= 1'b0;
        end
        ST_GAP2: if (tc) begin
          xfer_cnt <= next_cnt;
          if (burst_end) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_pend <= 1'b0;
          end else begin
            state <= ST_PH1;
            phi1  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          phi1  <= 1'b0;
          phi2  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_phase_sequencer.sv
// Testbench for latch_phase_sequencer: directed and random bursts.
// The driver pushes one expected-burst record per start; a negedge monitor
// derives expected outputs from phase arithmetic and compares every cycle.
module tb_latch_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] ph_width = '0;
  logic [3:0] gap_width = '0;
  logic [7:0] burst_len = '0;
  logic       phi1, phi2, busy, done;
  logic [7:0] xfer_cnt;

  latch_phase_sequencer #(.CNT_W(4), .BURST_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .ph_width  (ph_width),
    .gap_width (gap_width),
    .burst_len (burst_len),
    .phi1      (phi1),
    .phi2      (phi2),
    .busy      (busy),
    .done      (done),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start_cyc;
    int n;
    int pw;
    int gw;
    int abort_cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   dones_seen = 0;
  int   dones_exp = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp_v);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t cur;
  bit   active = 1'b0;
  int   last_xfer = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!active && q.size() > 0 && cyc > q[0].start_cyc) begin
        cur    = q.pop_front();
        active = 1'b1;
      end
      if (active) begin
        int t, p, pos;
        t = cyc - cur.start_cyc;
        p = 2 * (cur.pw + cur.gw);
        if (cur.abort_cyc >= 0 && cyc == cur.abort_cyc + 1) begin
          chk("rst_phi1", phi1, 0);
          chk("rst_phi2", phi2, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_xfer", xfer_cnt, 0);
          last_xfer = 0;
          active    = 1'b0;
        end else if (cur.abort_cyc >= 0 || t <= cur.n * p) begin
          pos = (t - 1) % p;
          chk("phi1", phi1, (pos < cur.pw) ? 1 : 0);
          chk("phi2", phi2, (pos >= cur.pw + cur.gw && pos < 2 * cur.pw + cur.gw) ? 1 : 0);
          chk("busy", busy, 1);
          chk("done_early", done, 0);
          chk("xfer_run", xfer_cnt, (t - 1) / p);
        end else begin
          chk("done_pulse", done, 1);
          chk("busy_fall", busy, 0);
          chk("end_phi1", phi1, 0);
          chk("end_phi2", phi2, 0);
          chk("xfer_final", xfer_cnt, cur.n);
          dones_seen++;
          last_xfer = cur.n;
          active    = 1'b0;
        end
      end else begin
        chk("idle_phi1", phi1, 0);
        chk("idle_phi2", phi2, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_xfer", xfer_cnt, last_xfer);
      end
      chk("overlap", phi1 & phi2, 0);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rnd_stop);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      stop      = rnd_stop ? 1'($urandom_range(0, 1)) : 1'b0;
      ph_width  = 4'($urandom_range(0, 15));
      gap_width = 4'($urandom_range(0, 15));
      burst_len = 8'($urandom_range(0, 255));
      tick();
    end
    stop = 1'b0;
  endtask

  // stop_t / rst_t are offsets from the start cycle, -1 for none.
  task automatic run_burst(input int pw_in, input int gw_in, input int bl,
                           input int stop_t, input int rst_t, input bit junk);
    exp_t e;
    int pw, gw, p, ns, n, end_t;
    pw = (pw_in < 1) ? 1 : pw_in;
    gw = (gw_in < 1) ? 1 : gw_in;
    p  = 2 * (pw + gw);
    if (stop_t < 0)       ns = 1000;
    else if (stop_t == 0) ns = 1;
    else                  ns = (stop_t + p - 1) / p;
    n = (bl == 0) ? ns : ((bl < ns) ? bl : ns);
    end_t = (rst_t >= 0) ? rst_t : n * p;
    e.start_cyc = cyc;
    e.n         = n;
    e.pw        = pw;
    e.gw        = gw;
    e.abort_cyc = (rst_t >= 0) ? cyc + rst_t : -1;
    q.push_back(e);
    if (rst_t < 0) dones_exp++;
    start     = 1'b1;
    stop      = (stop_t == 0);
    ph_width  = 4'(pw_in);
    gap_width = 4'(gw_in);
    burst_len = 8'(bl);
    tick();
    for (int t = 1; t <= end_t; t++) begin
      start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        ph_width  = 4'($urandom_range(0, 15));
        gap_width = 4'($urandom_range(0, 15));
        burst_len = 8'($urandom_range(0, 255));
      end
      stop = (t == stop_t);
      rst  = (t == rst_t);
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    // Reset with start/stop asserted: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    idle(2, 1'b1);

    run_burst(2, 1, 3, -1, -1, 1'b0);   // phi1 1-2,7-8; phi2 4-5; done at 19
    idle(3, 1'b1);
    run_burst(0, 0, 2, -1, -1, 1'b0);   // 1-cycle states, done at 9
    idle(2, 1'b0);
    run_burst(3, 2, 0, 36, -1, 1'b0);   // stop mid-PH2 of transfer 4
    idle(2, 1'b1);
    run_burst(4, 3, 0, 0, -1, 1'b0);    // start+stop together: one transfer
    idle(1, 1'b0);
    run_burst(2, 2, 4, -1, 11, 1'b0);   // reset in GAP1 of transfer 2
    idle(3, 1'b0);
    run_burst(1, 2, 2, -1, -1, 1'b0);   // normal run after reset
    run_burst(2, 2, 3, -1, -1, 1'b1);   // start/config churn while busy
    idle(1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int pw, gw, bl, p, st;
      pw = $urandom_range(0, 5);
      gw = $urandom_range(0, 4);
      bl = $urandom_range(0, 4);
      p  = 2 * (((pw < 1) ? 1 : pw) + ((gw < 1) ? 1 : gw));
      if (bl == 0)                          st = $urandom_range(0, 4 * p);
      else if ($urandom_range(0, 9) < 3)    st = $urandom_range(0, bl * p);
      else                                  st = -1;
      if ($urandom_range(0, 9) == 0)
        run_burst(pw, gw, (bl == 0) ? 3 : bl, -1, $urandom_range(1, p), 1'($urandom_range(0, 1)));
      else
        run_burst(pw, gw, bl, st, -1, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3), 1'b1);
    end

    begin
      int budget;
      budget = 0;
      while ((q.size() > 0 || active) && budget < 200) begin
        tick();
        budget++;
      end
      chk("drain_timeout", (q.size() > 0 || active) ? 1 : 0, 0);
    end
    idle(2, 1'b0);
    chk("done_count", dones_seen, dones_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
